// File: rtl/dual_issue_operand_stage.sv
// dual_issue_operand_stage
//   Issue / operand-fetch stage sitting directly in front of the dual-port
//   register file. It accepts a decoded instruction pair (slots a and b),
//   checks read-after-write and write-after-write hazards against a
//   one-bit-per-register scoreboard, and drives the four register-file read
//   ports. Issued operands are registered into the ID/EX register. Issue is
//   in order: slot b never goes before slot a. A pair whose b depends on a
//   is split over two or more cycles.
//
// Optional feature (macro WB_BYPASS_EN):
//   defined   - a source matching an active writeback port this cycle takes
//               the writeback data and is not treated as a hazard.
//   undefined - operands come only from the register file; a consumer waits
//               until the cycle after the writeback edge.
//
// Ports:
//   clk, reset                  clock (rising edge), synchronous active-low reset
//   in_valid / in_ready         pair handshake
//   in_{a,b}_vld/src0/src1/dst/wr/ctl   decoded slot contents
//   rd_addr_{a,b}{0,1}          register-file read addresses (0 when empty)
//   rd_data_{a,b}{0,1}          register-file read data (same cycle)
//   wb_en/wb_addr/wb_data_{a,b} writeback ports (shared with the register file)
//   out_ready                   execute stage can accept
//   ex_{a,b}_valid/op0/op1/dst/wr/ctl   ID/EX register outputs
module dual_issue_operand_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTL_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_a_vld,
  input  logic [ADDR_W-1:0] in_a_src0,
  input  logic [ADDR_W-1:0] in_a_src1,
  input  logic [ADDR_W-1:0] in_a_dst,
  input  logic              in_a_wr,
  input  logic [CTL_W-1:0]  in_a_ctl,
  input  logic              in_b_vld,
  input  logic [ADDR_W-1:0] in_b_src0,
  input  logic [ADDR_W-1:0] in_b_src1,
  input  logic [ADDR_W-1:0] in_b_dst,
  input  logic              in_b_wr,
  input  logic [CTL_W-1:0]  in_b_ctl,
  output logic [ADDR_W-1:0] rd_addr_a0,
  output logic [ADDR_W-1:0] rd_addr_a1,
  output logic [ADDR_W-1:0] rd_addr_b0,
  output logic [ADDR_W-1:0] rd_addr_b1,
  input  logic [DATA_W-1:0] rd_data_a0,
  input  logic [DATA_W-1:0] rd_data_a1,
  input  logic [DATA_W-1:0] rd_data_b0,
  input  logic [DATA_W-1:0] rd_data_b1,
  input  logic              wb_en_a,
  input  logic [ADDR_W-1:0] wb_addr_a,
  input  logic [DATA_W-1:0] wb_data_a,
  input  logic              wb_en_b,
  input  logic [ADDR_W-1:0] wb_addr_b,
  input  logic [DATA_W-1:0] wb_data_b,
  input  logic              out_ready,
  output logic              ex_a_valid,
  output logic [DATA_W-1:0] ex_a_op0,
  output logic [DATA_W-1:0] ex_a_op1,
  output logic [ADDR_W-1:0] ex_a_dst,
  output logic              ex_a_wr,
  output logic [CTL_W-1:0]  ex_a_ctl,
  output logic              ex_b_valid,
  output logic [DATA_W-1:0] ex_b_op0,
  output logic [DATA_W-1:0] ex_b_op1,
  output logic [ADDR_W-1:0] ex_b_dst,
  output logic              ex_b_wr,
  output logic [CTL_W-1:0]  ex_b_ctl
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [1:0] {EMPTY, PAIR, B_ONLY} state_t;

  state_t state, state_nxt;

  logic              h_a_vld, h_a_wr, h_b_vld, h_b_wr;
  logic [ADDR_W-1:0] h_a_src0, h_a_src1, h_a_dst;
  logic [ADDR_W-1:0] h_b_src0, h_b_src1, h_b_dst;
  logic [CTL_W-1:0]  h_a_ctl, h_b_ctl;

  logic [NREG-1:0] sb, sb_nxt;

  logic [3:0][ADDR_W-1:0] src_addr;
  logic [3:0][DATA_W-1:0] rdat;
  logic [3:0][DATA_W-1:0] opnd;
  logic [3:0]             src_hz;

  logic adv, hz_a, hz_b, dep;
  logic a_go, b_go, a_done, b_done, all_done, accept;

  // Source order: 0/1 = slot a, 2/3 = slot b
  assign src_addr = {h_b_src1, h_b_src0, h_a_src1, h_a_src0};
  assign rdat     = {rd_data_b1, rd_data_b0, rd_data_a1, rd_data_a0};

  // Register-file read addresses come straight from the holding register
  always_comb begin
    rd_addr_a0 = '0;
    rd_addr_a1 = '0;
    rd_addr_b0 = '0;
    rd_addr_b1 = '0;
    if (state != EMPTY) begin
      rd_addr_a0 = h_a_src0;
      rd_addr_a1 = h_a_src1;
      rd_addr_b0 = h_b_src0;
      rd_addr_b1 = h_b_src1;
    end
  end

`ifdef WB_BYPASS_EN
  // A source hit by a writeback this cycle takes that data and is free;
  // port b is applied last so it wins when both ports match.
  always_comb begin
    opnd   = rdat;
    src_hz = '0;
    for (int i = 0; i < 4; i++) begin
      src_hz[i] = sb[src_addr[i]];
      if (wb_en_a && (wb_addr_a == src_addr[i])) begin
        opnd[i]   = wb_data_a;
        src_hz[i] = 1'b0;
      end
      if (wb_en_b && (wb_addr_b == src_addr[i])) begin
        opnd[i]   = wb_data_b;
        src_hz[i] = 1'b0;
      end
    end
  end
`else
  logic unused_wb_data;
  assign unused_wb_data = ^{wb_data_a, wb_data_b};

  always_comb begin
    opnd   = rdat;
    src_hz = '0;
    for (int i = 0; i < 4; i++) begin
      src_hz[i] = sb[src_addr[i]];
    end
  end
`endif

  assign hz_a = src_hz[0] | src_hz[1] | (h_a_wr & sb[h_a_dst]);
  assign hz_b = src_hz[2] | src_hz[3] | (h_b_wr & sb[h_b_dst]);

  // b cannot travel with a when it touches the register a is about to write
  assign dep = h_a_vld & h_a_wr &
               ((h_b_src0 == h_a_dst) | (h_b_src1 == h_a_dst) | (h_b_dst == h_a_dst));

  assign adv = out_ready | ~(ex_a_valid | ex_b_valid);

  // Issue decision and next state; an absent slot counts as already issued
  always_comb begin
    state_nxt = state;
    a_go      = 1'b0;
    b_go      = 1'b0;
    a_done    = 1'b0;
    b_done    = 1'b0;
    all_done  = 1'b0;
    case (state)
      EMPTY: begin
        all_done = 1'b1;
      end
      PAIR: begin
        a_go     = h_a_vld & adv & ~hz_a;
        a_done   = ~h_a_vld | a_go;
        b_go     = h_b_vld & adv & ~hz_b & a_done & ~dep;
        b_done   = ~h_b_vld | b_go;
        all_done = a_done & b_done;
        if (a_done && !b_done) begin
          state_nxt = B_ONLY;
        end
      end
      B_ONLY: begin
        b_go     = adv & ~hz_b;
        all_done = b_go;
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
    in_ready = reset & all_done;
    accept   = in_valid & in_ready & (in_a_vld | in_b_vld);
    if (all_done) begin
      state_nxt = accept ? PAIR : EMPTY;
    end
  end

  // Scoreboard: writebacks clear first, then issued writers set (set wins)
  always_comb begin
    sb_nxt = sb;
    if (wb_en_a) sb_nxt[wb_addr_a] = 1'b0;
    if (wb_en_b) sb_nxt[wb_addr_b] = 1'b0;
    if (a_go && h_a_wr) sb_nxt[h_a_dst] = 1'b1;
    if (b_go && h_b_wr) sb_nxt[h_b_dst] = 1'b1;
  end

  // State, scoreboard, holding register and ID/EX register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= EMPTY;
      sb         <= '0;
      h_a_vld    <= 1'b0;
      h_a_src0   <= '0;
      h_a_src1   <= '0;
      h_a_dst    <= '0;
      h_a_wr     <= 1'b0;
      h_a_ctl    <= '0;
      h_b_vld    <= 1'b0;
      h_b_src0   <= '0;
      h_b_src1   <= '0;
      h_b_dst    <= '0;
      h_b_wr     <= 1'b0;
      h_b_ctl    <= '0;
      ex_a_valid <= 1'b0;
      ex_a_op0   <= '0;
      ex_a_op1   <= '0;
      ex_a_dst   <= '0;
      ex_a_wr    <= 1'b0;
      ex_a_ctl   <= '0;
      ex_b_valid <= 1'b0;
      ex_b_op0   <= '0;
      ex_b_op1   <= '0;
      ex_b_dst   <= '0;
      ex_b_wr    <= 1'b0;
      ex_b_ctl   <= '0;
    end else begin
      state <= state_nxt;
      sb    <= sb_nxt;
      if (accept) begin
        h_a_vld  <= in_a_vld;
        h_a_src0 <= in_a_src0;
        h_a_src1 <= in_a_src1;
        h_a_dst  <= in_a_dst;
        h_a_wr   <= in_a_wr;
        h_a_ctl  <= in_a_ctl;
        h_b_vld  <= in_b_vld;
        h_b_src0 <= in_b_src0;
        h_b_src1 <= in_b_src1;
        h_b_dst  <= in_b_dst;
        h_b_wr   <= in_b_wr;
        h_b_ctl  <= in_b_ctl;
      end
      // Payload fields hold when a lane goes idle; only valid/wr drop
      if (adv) begin
        ex_a_valid <= a_go;
        ex_a_wr    <= a_go & h_a_wr;
        if (a_go) begin
          ex_a_op0 <= opnd[0];
          ex_a_op1 <= opnd[1];
          ex_a_dst <= h_a_dst;
          ex_a_ctl <= h_a_ctl;
        end
        ex_b_valid <= b_go;
        ex_b_wr    <= b_go & h_b_wr;
        if (b_go) begin
          ex_b_op0 <= opnd[2];
          ex_b_op1 <= opnd[3];
          ex_b_dst <= h_b_dst;
          ex_b_ctl <= h_b_ctl;
        end
      end
    end
  end

endmodule

// File: tb/tb_dual_issue_operand_stage.sv
// tb_dual_issue_operand_stage
//   Bench for dual_issue_operand_stage. Holds a small register file, a list
//   of pending instructions in program order and a busy-register set, and
//   predicts issue, in_ready, read addresses and the ID/EX contents each
//   cycle. Directed scenarios come first, then randomized traffic.
module tb_dual_issue_operand_stage;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CTL_W  = 16;
  localparam int NREG   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready;
  logic              in_a_vld, in_a_wr, in_b_vld, in_b_wr;
  logic [ADDR_W-1:0] in_a_src0, in_a_src1, in_a_dst;
  logic [ADDR_W-1:0] in_b_src0, in_b_src1, in_b_dst;
  logic [CTL_W-1:0]  in_a_ctl, in_b_ctl;
  logic [ADDR_W-1:0] rd_addr_a0, rd_addr_a1, rd_addr_b0, rd_addr_b1;
  logic [DATA_W-1:0] rd_data_a0, rd_data_a1, rd_data_b0, rd_data_b1;
  logic              wb_en_a, wb_en_b;
  logic [ADDR_W-1:0] wb_addr_a, wb_addr_b;
  logic [DATA_W-1:0] wb_data_a, wb_data_b;
  logic              out_ready;
  logic              ex_a_valid, ex_a_wr, ex_b_valid, ex_b_wr;
  logic [DATA_W-1:0] ex_a_op0, ex_a_op1, ex_b_op0, ex_b_op1;
  logic [ADDR_W-1:0] ex_a_dst, ex_b_dst;
  logic [CTL_W-1:0]  ex_a_ctl, ex_b_ctl;

  always #5 clk = ~clk;

  dual_issue_operand_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTL_W(CTL_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a_vld(in_a_vld), .in_a_src0(in_a_src0), .in_a_src1(in_a_src1),
    .in_a_dst(in_a_dst), .in_a_wr(in_a_wr), .in_a_ctl(in_a_ctl),
    .in_b_vld(in_b_vld), .in_b_src0(in_b_src0), .in_b_src1(in_b_src1),
    .in_b_dst(in_b_dst), .in_b_wr(in_b_wr), .in_b_ctl(in_b_ctl),
    .rd_addr_a0(rd_addr_a0), .rd_addr_a1(rd_addr_a1),
    .rd_addr_b0(rd_addr_b0), .rd_addr_b1(rd_addr_b1),
    .rd_data_a0(rd_data_a0), .rd_data_a1(rd_data_a1),
    .rd_data_b0(rd_data_b0), .rd_data_b1(rd_data_b1),
    .wb_en_a(wb_en_a), .wb_addr_a(wb_addr_a), .wb_data_a(wb_data_a),
    .wb_en_b(wb_en_b), .wb_addr_b(wb_addr_b), .wb_data_b(wb_data_b),
    .out_ready(out_ready),
    .ex_a_valid(ex_a_valid), .ex_a_op0(ex_a_op0), .ex_a_op1(ex_a_op1),
    .ex_a_dst(ex_a_dst), .ex_a_wr(ex_a_wr), .ex_a_ctl(ex_a_ctl),
    .ex_b_valid(ex_b_valid), .ex_b_op0(ex_b_op0), .ex_b_op1(ex_b_op1),
    .ex_b_dst(ex_b_dst), .ex_b_wr(ex_b_wr), .ex_b_ctl(ex_b_ctl)
  );

  // Register file: identity contents while in reset, port b written last
  logic [DATA_W-1:0] rf [NREG];

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= DATA_W'(i);
    end else begin
      if (wb_en_a) rf[wb_addr_a] <= wb_data_a;
      if (wb_en_b) rf[wb_addr_b] <= wb_data_b;
    end
  end

  assign rd_data_a0 = rf[rd_addr_a0];
  assign rd_data_a1 = rf[rd_addr_a1];
  assign rd_data_b0 = rf[rd_addr_b0];
  assign rd_data_b1 = rf[rd_addr_b1];

  // Reference model state
  typedef struct packed {
    logic [ADDR_W-1:0] s0;
    logic [ADDR_W-1:0] s1;
    logic [ADDR_W-1:0] d;
    logic              wr;
    logic [CTL_W-1:0]  ctl;
    logic              lane_b;
  } instr_t;

  typedef struct packed {
    logic              v;
    logic [DATA_W-1:0] op0;
    logic [DATA_W-1:0] op1;
    logic [ADDR_W-1:0] d;
    logic              wr;
    logic [CTL_W-1:0]  ctl;
  } lane_t;

  instr_t          pend[$];
  instr_t          nxt_pend[$];
  logic [NREG-1:0] busy, nxt_busy;
  lane_t           cur_a, cur_b, nxt_a, nxt_b;
  bit              exp_ready;
  bit              synced, nxt_synced;

  int n_vec = 0;
  int n_mis = 0;
  int n_cmp = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit bypassed(input logic [ADDR_W-1:0] r);
`ifdef WB_BYPASS_EN
    return (wb_en_a && wb_addr_a == r) || (wb_en_b && wb_addr_b == r);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] operand(input logic [ADDR_W-1:0] r);
`ifdef WB_BYPASS_EN
    if (wb_en_b && wb_addr_b == r) return wb_data_b;
    if (wb_en_a && wb_addr_a == r) return wb_data_a;
`endif
    return rf[r];
  endfunction

  // Greedy in-order issue over the pending list, evaluated just before the edge
  task automatic predict();
    int    n_issue;
    bit    adv_m, blocked, stop;
    lane_t ln;
    n_issue = 0;
    stop    = 0;
    adv_m   = out_ready || !(cur_a.v || cur_b.v);
    if (reset && adv_m) begin
      for (int k = 0; k < pend.size(); k++) begin
        if (!stop) begin
          blocked = (busy[pend[k].s0] && !bypassed(pend[k].s0)) ||
                    (busy[pend[k].s1] && !bypassed(pend[k].s1)) ||
                    (pend[k].wr && busy[pend[k].d]);
          for (int j = 0; j < k; j++) begin
            if (pend[j].wr && (pend[j].d == pend[k].s0 || pend[j].d == pend[k].s1 ||
                               pend[j].d == pend[k].d))
              blocked = 1;
          end
          if (blocked) stop = 1;
          else n_issue++;
        end
      end
    end
    exp_ready = reset && (n_issue == pend.size());
    nxt_a     = cur_a;
    nxt_b     = cur_b;
    nxt_busy  = busy;
    nxt_pend  = pend;
    if (!reset) begin
      nxt_a      = '0;
      nxt_b      = '0;
      nxt_busy   = '0;
      nxt_synced = 1;
      nxt_pend.delete();
    end else begin
      nxt_synced = synced;
      if (adv_m) begin
        nxt_a.v  = 0;
        nxt_a.wr = 0;
        nxt_b.v  = 0;
        nxt_b.wr = 0;
      end
      if (wb_en_a) nxt_busy[wb_addr_a] = 1'b0;
      if (wb_en_b) nxt_busy[wb_addr_b] = 1'b0;
      for (int k = 0; k < n_issue; k++) begin
        ln.v   = 1;
        ln.op0 = operand(pend[k].s0);
        ln.op1 = operand(pend[k].s1);
        ln.d   = pend[k].d;
        ln.wr  = pend[k].wr;
        ln.ctl = pend[k].ctl;
        if (pend[k].lane_b) nxt_b = ln;
        else nxt_a = ln;
        if (pend[k].wr) nxt_busy[pend[k].d] = 1'b1;
      end
      for (int k = 0; k < n_issue; k++) void'(nxt_pend.pop_front());
      if (in_valid && exp_ready) begin
        if (in_a_vld) nxt_pend.push_back('{in_a_src0, in_a_src1, in_a_dst, in_a_wr, in_a_ctl, 1'b0});
        if (in_b_vld) nxt_pend.push_back('{in_b_src0, in_b_src1, in_b_dst, in_b_wr, in_b_ctl, 1'b1});
      end
    end
  endtask

  task automatic checkOutput(input bit pre_edge);
    if (pre_edge) begin
      if (synced) begin
        chk("in_ready", in_ready, exp_ready);
        if (pend.size() == 0) begin
          chk("rd_addr_a0_idle", rd_addr_a0, 0);
          chk("rd_addr_a1_idle", rd_addr_a1, 0);
          chk("rd_addr_b0_idle", rd_addr_b0, 0);
          chk("rd_addr_b1_idle", rd_addr_b1, 0);
        end
        foreach (pend[k]) begin
          if (pend[k].lane_b) begin
            chk("rd_addr_b0", rd_addr_b0, pend[k].s0);
            chk("rd_addr_b1", rd_addr_b1, pend[k].s1);
          end else begin
            chk("rd_addr_a0", rd_addr_a0, pend[k].s0);
            chk("rd_addr_a1", rd_addr_a1, pend[k].s1);
          end
        end
      end
    end else begin
      chk("ex_a_valid", ex_a_valid, nxt_a.v);
      chk("ex_a_wr",    ex_a_wr,    nxt_a.wr);
      chk("ex_a_op0",   ex_a_op0,   nxt_a.op0);
      chk("ex_a_op1",   ex_a_op1,   nxt_a.op1);
      chk("ex_a_dst",   ex_a_dst,   nxt_a.d);
      chk("ex_a_ctl",   ex_a_ctl,   nxt_a.ctl);
      chk("ex_b_valid", ex_b_valid, nxt_b.v);
      chk("ex_b_wr",    ex_b_wr,    nxt_b.wr);
      chk("ex_b_op0",   ex_b_op0,   nxt_b.op0);
      chk("ex_b_op1",   ex_b_op1,   nxt_b.op1);
      chk("ex_b_dst",   ex_b_dst,   nxt_b.d);
      chk("ex_b_ctl",   ex_b_ctl,   nxt_b.ctl);
    end
  endtask

  // One clock: predict and check before the edge, check the ID/EX result after it
  task automatic step();
    #3;
    predict();
    checkOutput(1'b1);
    @(posedge clk);
    #1;
    checkOutput(1'b0);
    cur_a  = nxt_a;
    cur_b  = nxt_b;
    busy   = nxt_busy;
    pend   = nxt_pend;
    synced = nxt_synced;
    n_vec++;
  endtask

  task automatic loadPair(input logic av, input logic [ADDR_W-1:0] as0, input logic [ADDR_W-1:0] as1,
                          input logic [ADDR_W-1:0] ad, input logic aw,
                          input logic bv, input logic [ADDR_W-1:0] bs0, input logic [ADDR_W-1:0] bs1,
                          input logic [ADDR_W-1:0] bd, input logic bw);
    in_valid  = 1'b1;
    in_a_vld  = av;  in_a_src0 = as0; in_a_src1 = as1; in_a_dst = ad; in_a_wr = aw;
    in_a_ctl  = CTL_W'($urandom);
    in_b_vld  = bv;  in_b_src0 = bs0; in_b_src1 = bs1; in_b_dst = bd; in_b_wr = bw;
    in_b_ctl  = CTL_W'($urandom);
  endtask

  task automatic setWb(input logic ea, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] da,
                       input logic eb, input logic [ADDR_W-1:0] ab, input logic [DATA_W-1:0] db);
    wb_en_a = ea; wb_addr_a = aa; wb_data_a = da;
    wb_en_b = eb; wb_addr_b = ab; wb_data_b = db;
  endtask

  task automatic applyStimulus();
    int busy_list[$];
    reset     = ($urandom_range(0, 199) != 0);
    in_valid  = ($urandom_range(0, 9) < 7);
    out_ready = ($urandom_range(0, 3) != 0);
    in_a_vld  = ($urandom_range(0, 7) != 0);
    in_a_src0 = ADDR_W'($urandom_range(0, 11));
    in_a_src1 = ADDR_W'($urandom_range(0, 11));
    in_a_dst  = ADDR_W'($urandom_range(0, 11));
    in_a_wr   = ($urandom_range(0, 3) != 0);
    in_a_ctl  = CTL_W'($urandom);
    in_b_vld  = ($urandom_range(0, 7) != 0);
    in_b_src0 = ADDR_W'($urandom_range(0, 11));
    in_b_src1 = ADDR_W'($urandom_range(0, 11));
    in_b_dst  = ADDR_W'($urandom_range(0, 11));
    in_b_wr   = ($urandom_range(0, 3) != 0);
    in_b_ctl  = CTL_W'($urandom);
    for (int r = 0; r < NREG; r++) if (busy[r]) busy_list.push_back(r);
    wb_en_a   = ($urandom_range(0, 1) == 1);
    wb_en_b   = ($urandom_range(0, 2) == 2);
    wb_addr_a = (busy_list.size() > 0) ? ADDR_W'(busy_list[$urandom_range(0, busy_list.size() - 1)])
                                       : ADDR_W'($urandom_range(0, 11));
    wb_addr_b = (busy_list.size() > 0) ? ADDR_W'(busy_list[$urandom_range(0, busy_list.size() - 1)])
                                       : ADDR_W'($urandom_range(0, 11));
    wb_data_a = $urandom;
    wb_data_b = $urandom;
  endtask

  initial begin
    cur_a  = '0;
    cur_b  = '0;
    busy   = '0;
    synced = 0;
    reset  = 1'b0;
    out_ready = 1'b1;
    loadPair(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    setWb(0, 0, 0, 0, 0, 0);

    // Reset for two clocks, then release
    step();
    step();
    chk("rst_ex_a_valid", ex_a_valid, 0);
    chk("rst_ex_b_valid", ex_b_valid, 0);
    chk("rst_ex_a_op0", ex_a_op0, 0);
    chk("rst_ex_b_ctl", ex_b_ctl, 0);
    chk("rst_sb", dut.sb, 0);
    chk("rst_rd_addr", {rd_addr_a0, rd_addr_a1, rd_addr_b0, rd_addr_b1}, 0);
    reset = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Independent pair issues both lanes one cycle after accept
    loadPair(1, 4, 5, 10, 1, 1, 6, 7, 11, 1);
    step();
    in_valid = 1'b0;
    step();
    chk("pair_a_valid", ex_a_valid, 1);
    chk("pair_a_op0", ex_a_op0, 4);
    chk("pair_a_op1", ex_a_op1, 5);
    chk("pair_b_op0", ex_b_op0, 6);
    chk("pair_b_op1", ex_b_op1, 7);
    chk("pair_sb10", dut.sb[10], 1);
    chk("pair_sb11", dut.sb[11], 1);
    chk("model_busy10", busy[10], 1);
    setWb(1, 10, 100, 1, 11, 110);
    step();
    setWb(0, 0, 0, 0, 0, 0);

    // b reads a's destination: pair splits, b waits for the writeback
    loadPair(1, 1, 2, 10, 1, 1, 10, 3, 12, 1);
    step();
    in_valid = 1'b0;
    step();
    chk("split_a_valid", ex_a_valid, 1);
    chk("split_b_valid", ex_b_valid, 0);
    #1;
    chk("split_in_ready", in_ready, 0);
    setWb(1, 10, 40, 0, 0, 0);
    step();
`ifdef WB_BYPASS_EN
    chk("byp_b_valid", ex_b_valid, 1);
    chk("byp_b_op0", ex_b_op0, 40);
    setWb(0, 0, 0, 0, 0, 0);
`else
    chk("nobyp_b_wait", ex_b_valid, 0);
    setWb(0, 0, 0, 0, 0, 0);
    step();
    chk("nobyp_b_valid", ex_b_valid, 1);
    chk("nobyp_b_op0", ex_b_op0, 40);
`endif
    chk("split_b_op1", ex_b_op1, 3);
    setWb(0, 0, 0, 1, 12, 12);
    step();
    setWb(0, 0, 0, 0, 0, 0);

    // Back-to-back pairs, then a three-cycle execute stall
    loadPair(1, 1, 2, 13, 1, 1, 3, 4, 14, 1);
    step();
    loadPair(1, 5, 6, 16, 1, 1, 7, 1, 17, 1);
    step();
    chk("b2b_a_op0", ex_a_op0, 1);
    chk("b2b_b_op1", ex_b_op1, 4);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", in_ready, 0);
      step();
      chk("stall_a_valid", ex_a_valid, 1);
      chk("stall_a_op0", ex_a_op0, 1);
      chk("stall_b_op1", ex_b_op1, 4);
      chk("stall_sb16", dut.sb[16], 0);
    end
    out_ready = 1'b1;
    step();
    chk("resume_a_op0", ex_a_op0, 5);
    chk("resume_a_op1", ex_a_op1, 6);
    chk("resume_b_op0", ex_b_op0, 7);
    chk("resume_b_op1", ex_b_op1, 1);
    chk("resume_sb16", dut.sb[16], 1);
    setWb(1, 13, 0, 1, 14, 0);
    step();
    setWb(1, 16, 0, 1, 17, 0);
    step();
    setWb(0, 0, 0, 0, 0, 0);

    // Set beats clear on one address; double clear on another
    loadPair(1, 1, 2, 15, 1, 1, 3, 4, 20, 1);
    step();
    in_valid = 1'b0;
    setWb(0, 0, 0, 1, 15, 55);
    step();
    chk("setwins_sb15", dut.sb[15], 1);
    chk("setwins_sb20", dut.sb[20], 1);
    setWb(1, 20, 32'h77, 1, 20, 32'h78);
    step();
    chk("dblclr_sb20", dut.sb[20], 0);
    chk("dblclr_sb15", dut.sb[15], 1);
    chk("model_busy15", busy[15], 1);
    setWb(1, 15, 0, 0, 0, 0);
    step();
    setWb(0, 0, 0, 0, 0, 0);

    // Reset while b is still waiting: b is dropped for good
    loadPair(1, 1, 2, 21, 1, 1, 21, 3, 22, 1);
    step();
    in_valid = 1'b0;
    step();
    chk("drop_a_valid", ex_a_valid, 1);
    chk("drop_b_pending", ex_b_valid, 0);
    reset = 1'b0;
    step();
    chk("drop_rst_a_valid", ex_a_valid, 0);
    chk("drop_rst_sb21", dut.sb[21], 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("drop_b_never", ex_b_valid, 0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      applyStimulus();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
